// File: rtl/arb_pkg.sv
// ============================================================================
// Module      : arb_pkg
// Description : Shared types, sizes and helpers for the round-robin arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package arb_pkg;

    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    function automatic logic [N_REQ-1:0] onehot_from_id(input logic [ID_W-1:0] id);
        logic [N_REQ-1:0] oh;
        oh     = '0;
        oh[id] = 1'b1;
        return oh;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter_if.sv
// ============================================================================
// Module      : rr_arbiter_if
// Description : Request/grant bundle between the clients and the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rr_arbiter_if;
    import arb_pkg::*;

    logic [N_REQ-1:0] req;
    // "release" is a reserved SystemVerilog keyword, hence the short name.
    logic             rel;
    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0]  gnt_id;
    logic             valid;
    logic             timeout;

    modport master (
        output req,
        output rel,
        input  gnt,
        input  gnt_id,
        input  valid,
        input  timeout
    );

    modport slave (
        input  req,
        input  rel,
        output gnt,
        output gnt_id,
        output valid,
        output timeout
    );

endinterface

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Combinational rotating-priority search starting at ptr.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [ID_W-1:0]  win_id,
    output logic             any
);

    logic [ID_W-1:0] idx;

    // Walk from the lowest priority upward so the highest-priority hit is written last.
    always_comb begin
        win_id = '0;
        any    = 1'b0;
        idx    = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = ptr + ID_W'(k);
            if (req[idx]) begin
                win_id = idx;
                any    = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Four-client round-robin arbiter with registered grant outputs.
//               Define ARB_TIMEOUT_EN to build the hold-limit revoke logic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 15,
    parameter int CNT_W    = 4
) (
    input  logic         clk,
    input  logic         rst,
    rr_arbiter_if.slave  arb
);

    if (CNT_W < 1 || MAX_HOLD < 1 || MAX_HOLD >= (1 << CNT_W)) begin : g_param_check
        $error("rr_arbiter: MAX_HOLD must lie in 1..2**CNT_W-1");
    end

    arb_state_e       state_q,   state_d;
    logic [ID_W-1:0]  ptr_q,     ptr_d;
    logic [N_REQ-1:0] gnt_q,     gnt_d;
    logic [ID_W-1:0]  gnt_id_q,  gnt_id_d;
    logic             valid_q,   valid_d;
    logic             timeout_q, timeout_d;

    logic [ID_W-1:0]  w_win_id;
    logic             w_any;
    logic             w_end_grant;
    logic             w_hold_limit;

    rr_pick u_pick (
        .req    (arb.req),
        .ptr    (ptr_q),
        .win_id (w_win_id),
        .any    (w_any)
    );

    assign w_end_grant = arb.rel | ~arb.req[gnt_id_q];

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] hcnt_q, hcnt_d;

    // hcnt counts completed cycles of the current grant, so the limit hits in cycle MAX_HOLD.
    assign w_hold_limit = (state_q == BUSY) && (hcnt_q == CNT_W'(MAX_HOLD - 1));

    always_comb begin
        hcnt_d = hcnt_q;
        if (state_q == IDLE) begin
            hcnt_d = '0;
        end else if (!w_end_grant && !w_hold_limit) begin
            hcnt_d = hcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
        end
    end
`else
    assign w_hold_limit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        valid_d   = valid_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_any) begin
                    state_d  = BUSY;
                    ptr_d    = w_win_id + 1'b1;
                    gnt_d    = onehot_from_id(w_win_id);
                    gnt_id_d = w_win_id;
                    valid_d  = 1'b1;
                end
            end
            BUSY: begin
                // An owner-initiated end wins over a simultaneous hold-limit revoke.
                if (w_end_grant) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    valid_d = 1'b0;
                end else if (w_hold_limit) begin
                    state_d   = IDLE;
                    gnt_d     = '0;
                    valid_d   = 1'b0;
                    timeout_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign arb.gnt     = gnt_q;
    assign arb.gnt_id  = gnt_id_q;
    assign arb.valid   = valid_q;
    assign arb.timeout = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_rr_arbiter.sv
// ============================================================================
// Module      : tb_rr_arbiter
// Description : Self-checking bench for rr_arbiter against a cycle-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_arbiter;
    import arb_pkg::*;

    localparam int TB_MAX_HOLD = 4;
    localparam int TB_CNT_W    = 3;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    // Reference model: owner index (-1 when idle), next search start, cycles held.
    int m_owner, m_ptr, m_last, m_hold;
    bit m_to;

    rr_arbiter_if arb_if ();

    rr_arbiter #(
        .MAX_HOLD (TB_MAX_HOLD),
        .CNT_W    (TB_CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .arb (arb_if)
    );

    always #5 clk = ~clk;

    logic [7:0] dut_vec;
    assign dut_vec = {arb_if.gnt, arb_if.gnt_id, arb_if.valid, arb_if.timeout};

    function automatic logic [7:0] exp_vec();
        logic [3:0] g;
        g = '0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return {g, 2'(m_last), (m_owner >= 0), m_to};
    endfunction

    task automatic model_edge();
        bit found;
        int idx;
        if (rst) begin
            m_owner = -1; m_ptr = 0; m_last = 0; m_hold = 0; m_to = 1'b0;
        end else if (m_owner < 0) begin
            m_to  = 1'b0;
            found = 1'b0;
            for (int k = 0; k < 4; k++) begin
                idx = (m_ptr + k) % 4;
                if (!found && arb_if.req[idx]) begin
                    found   = 1'b1;
                    m_owner = idx;
                    m_last  = idx;
                    m_ptr   = (idx + 1) % 4;
                    m_hold  = 1;
                end
            end
        end else begin
            m_to = 1'b0;
            if (arb_if.rel || !arb_if.req[m_owner]) begin
                m_owner = -1;
            end else if (TO_EN && m_hold == TB_MAX_HOLD) begin
                m_owner = -1;
                m_to    = 1'b1;
            end else begin
                m_hold = m_hold + 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; arb_if.req = '0; arb_if.rel = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; arb_if.req = 4'b1111; arb_if.rel = 1'b0;
        tick(); tick();
        checks++;
        if (dut_vec !== 8'b0000_00_0_0) begin
            errors++; $display("FAIL reset_values: got %b expected %b", dut_vec, 8'b0);
        end
        rst = 1'b0; arb_if.req = '0;
        tick();
        checks++;
        if (dut_vec !== exp_vec()) begin
            errors++; $display("FAIL reset_idle: got %b expected %b", dut_vec, exp_vec());
        end
    endtask

    task automatic test_single();
        arb_if.req = 4'b0001;
        tick();
        checks++;
        if (dut_vec !== {4'b0001, 2'd0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL single_grant: got %b expected %b", dut_vec, {4'b0001, 2'd0, 1'b1, 1'b0});
        end
        arb_if.rel = 1'b1;
        tick();
        checks++;
        if (arb_if.valid !== 1'b0 || dut_vec !== exp_vec()) begin
            errors++; $display("FAIL single_release: got %b expected %b", dut_vec, exp_vec());
        end
        arb_if.rel = 1'b0; arb_if.req = '0;
        tick();
    endtask

    task automatic test_all_round();
        int order [5];
        order = '{0, 1, 2, 3, 0};
        do_reset();
        arb_if.req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            tick();
            checks++;
            if (arb_if.valid !== 1'b1 || arb_if.gnt_id !== 2'(order[g]) || dut_vec !== exp_vec()) begin
                errors++; $display("FAIL round_order[%0d]: got %b expected %b", g, dut_vec, exp_vec());
            end
            arb_if.rel = 1'b1;
            tick();
            checks++;
            if (arb_if.valid !== 1'b0 || dut_vec !== exp_vec()) begin
                errors++; $display("FAIL round_bubble[%0d]: got %b expected %b", g, dut_vec, exp_vec());
            end
            arb_if.rel = 1'b0;
        end
        arb_if.req = '0;
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        arb_if.req = 4'b0010;
        tick();
        arb_if.rel = 1'b1; arb_if.req = '0;
        tick();
        arb_if.rel = 1'b0; arb_if.req = 4'b0011;
        tick();
        checks++;
        if (arb_if.gnt !== 4'b0001 || arb_if.gnt_id !== 2'd0 || dut_vec !== exp_vec()) begin
            errors++; $display("FAIL wrap_grant: got %b expected %b", dut_vec, exp_vec());
        end
        arb_if.rel = 1'b1;
        tick();
        arb_if.rel = 1'b0;
        tick();
        checks++;
        if (arb_if.gnt !== 4'b0010 || arb_if.gnt_id !== 2'd1 || dut_vec !== exp_vec()) begin
            errors++; $display("FAIL wrap_next: got %b expected %b", dut_vec, exp_vec());
        end
        arb_if.rel = 1'b1; arb_if.req = '0;
        tick();
        arb_if.rel = 1'b0;
    endtask

    task automatic test_owner_drop();
        do_reset();
        arb_if.req = 4'b1100;
        tick();
        checks++;
        if (arb_if.gnt !== 4'b0100 || dut_vec !== exp_vec()) begin
            errors++; $display("FAIL drop_first: got %b expected %b", dut_vec, exp_vec());
        end
        arb_if.req = 4'b1000;
        tick();
        checks++;
        if (arb_if.valid !== 1'b0 || dut_vec !== exp_vec()) begin
            errors++; $display("FAIL drop_end: got %b expected %b", dut_vec, exp_vec());
        end
        tick();
        checks++;
        if (arb_if.gnt !== 4'b1000 || arb_if.gnt_id !== 2'd3 || dut_vec !== exp_vec()) begin
            errors++; $display("FAIL drop_pending: got %b expected %b", dut_vec, exp_vec());
        end
        arb_if.rel = 1'b1; arb_if.req = '0;
        tick();
        arb_if.rel = 1'b0;
    endtask

    task automatic test_timeout();
        do_reset();
        arb_if.req = 4'b0110;
`ifdef ARB_TIMEOUT_EN
        for (int c = 0; c < TB_MAX_HOLD; c++) begin
            tick();
            checks++;
            if (dut_vec !== {4'b0010, 2'd1, 1'b1, 1'b0} || dut_vec !== exp_vec()) begin
                errors++; $display("FAIL timeout_hold[%0d]: got %b expected %b", c, dut_vec, exp_vec());
            end
        end
        tick();
        checks++;
        if (dut_vec !== {4'b0000, 2'd1, 1'b0, 1'b1} || dut_vec !== exp_vec()) begin
            errors++; $display("FAIL timeout_pulse: got %b expected %b", dut_vec, exp_vec());
        end
        tick();
        checks++;
        if (dut_vec !== {4'b0100, 2'd2, 1'b1, 1'b0} || dut_vec !== exp_vec()) begin
            errors++; $display("FAIL timeout_next: got %b expected %b", dut_vec, exp_vec());
        end
`else
        for (int c = 0; c < 20; c++) begin
            tick();
            checks++;
            if (dut_vec !== {4'b0010, 2'd1, 1'b1, 1'b0} || dut_vec !== exp_vec()) begin
                errors++; $display("FAIL no_timeout_hold[%0d]: got %b expected %b", c, dut_vec, exp_vec());
            end
        end
`endif
        arb_if.rel = 1'b1; arb_if.req = '0;
        tick();
        arb_if.rel = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        arb_if.req = 4'b1000;
        tick();
        checks++;
        if (arb_if.gnt !== 4'b1000 || dut_vec !== exp_vec()) begin
            errors++; $display("FAIL midrst_grant: got %b expected %b", dut_vec, exp_vec());
        end
        rst = 1'b1;
        tick();
        checks++;
        if (dut_vec !== 8'b0000_00_0_0) begin
            errors++; $display("FAIL midrst_clear: got %b expected %b", dut_vec, 8'b0);
        end
        rst = 1'b0; arb_if.req = 4'b1001;
        tick();
        checks++;
        if (dut_vec !== {4'b0001, 2'd0, 1'b1, 1'b0} || dut_vec !== exp_vec()) begin
            errors++; $display("FAIL midrst_regrant: got %b expected %b", dut_vec, exp_vec());
        end
        arb_if.rel = 1'b1; arb_if.req = '0;
        tick();
        arb_if.rel = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            arb_if.req = 4'($urandom_range(0, 15));
            arb_if.rel = ($urandom_range(0, 3) == 0);
            rst        = ($urandom_range(0, 199) == 0);
            tick();
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL random[%0d]: got %b expected %b", c, dut_vec, exp_vec());
            end
        end
        rst = 1'b0; arb_if.req = '0; arb_if.rel = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        m_owner = -1; m_ptr = 0; m_last = 0; m_hold = 0; m_to = 1'b0;
        rst = 1'b1; arb_if.req = '0; arb_if.rel = 1'b0;
        test_reset();
        test_single();
        test_all_round();
        test_wrap();
        test_owner_drop();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rr_arbiter.md
# rr_arbiter

Four-requester round-robin arbiter that shares one downstream resource, such as a priority-encoded datapath or a shared bus port, among four clients. The winner is chosen in rotating priority order starting after the previous winner. The arbiter holds the grant until the owner releases it, drops its request, or, optionally, exceeds a hold limit. It sits between the requesting blocks and the shared resource and drives the select (`gnt_id`) and `valid` for that resource.

## Interface
- `MAX_HOLD`, default 15: maximum cycles one grant may stay asserted (timeout build only); legal range 1..2^CNT_W-1.
- `CNT_W`, default 4: hold-counter width; must satisfy 2^CNT_W > MAX_HOLD.
- `clk`, input, 1: single clock; all logic on the rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `req`, input, 4: request per client; a client holds it high until it is served.
- `release`, input, 1: current owner ends its grant; ignored while idle.
- `gnt`, output, 4: one-hot registered grant; all zero when idle.
- `gnt_id`, output, 2: binary index of the owner; holds its last value when idle.
- `valid`, output, 1: high exactly when `gnt` is non-zero.
- `timeout`, output, 1: one-cycle pulse when a grant is revoked by the hold limit.

## Operation
- The arbiter has two states, IDLE and BUSY. It also keeps a 2-bit rotation pointer `ptr` and a hold counter `hcnt`.
- **Reset values:** state IDLE, `ptr`=0, `hcnt`=0, `gnt`=0000, `gnt_id`=00, `valid`=0, `timeout`=0.
- **IDLE with `req` = 0:** stay in IDLE; outputs stay at their idle values.
- **IDLE with any `req` bit set:**
  - Search the indices in the order `ptr`, `ptr`+1, `ptr`+2, `ptr`+3 (mod 4); the first set bit wins.
  - At the next edge: `gnt` = one-hot of the winner, `gnt_id` = winner, `valid`=1, `hcnt`=0, state BUSY.
  - `ptr` becomes winner+1 (mod 4); a pointer value of 3 wraps to 0.
- **BUSY, end of grant:** if `release`=1 or `req[gnt_id]`=0 in a cycle, the next edge clears `gnt`/`valid` and returns to IDLE. `ptr` is unchanged.
- **BUSY otherwise:** the grant holds, and `hcnt` increments (timeout build only).
- **Simultaneous `release` and the hold limit:** `release` takes priority, so `timeout` stays 0.
- **Request changes:**
  - Requests that rise or fall during BUSY are not sampled until the arbiter is back in IDLE.
  - A non-owner request does not pre-empt the current owner.
- **Reset during BUSY:** the next edge returns every register to its reset value. No `timeout` pulse is generated.

## Timing
- **Arbitration latency:** 1 cycle. A request sampled in IDLE produces `gnt`/`valid` at the following edge.
- **Release latency:** 1 cycle. `release` sampled at edge k means `valid`=0 after edge k.
- **Back-to-back grants:** there is a mandatory one-cycle IDLE bubble (`valid`=0) between consecutive grants.
- **Timeout (build with `ARB_TIMEOUT_EN`):**
  - `valid` stays high for at most MAX_HOLD consecutive cycles.
  - On the edge that ends the MAX_HOLD-th cycle: `gnt`=0, `valid`=0, `timeout`=1 for one cycle, state IDLE.
  - Arbitration resumes in that same IDLE cycle, with `ptr` already past the revoked owner.
- **Output timing:** all outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- **Macro:** `ARB_TIMEOUT_EN`.
- **Defined:** `hcnt` and the hold-limit revoke logic are built; `timeout` behaves as specified above.
- **Undefined:**
  - No counter is built, and `MAX_HOLD`/`CNT_W` are unused.
  - A grant lasts indefinitely until `release` or the owner's request drops.
  - `timeout` is tied to 0.

## Structure
- **Shared package `arb_pkg`:**
  - state encoding, IDLE=1'b0 and BUSY=1'b1;
  - `N_REQ`=4 and `ID_W`=2;
  - the one-hot-from-index helper function.
- **Sub-module `rr_pick`:** a combinational rotating-priority search.
  - Inputs `req[3:0]` and `ptr[1:0]`.
  - Outputs `win_id[1:0]` and `any`.
  - The top-level block registers the result.

## Test plan
1. **Single request:** hold `rst`=1 for 2 cycles, then `req`=0001 → one edge later `gnt`=0001, `gnt_id`=0, `valid`=1. Pulse `release` → `valid`=0 next cycle.
2. **All clients requesting:** `req`=1111, pulsing `release` on each grant → grant order 0,1,2,3,0. Each grant is separated by exactly one `valid`=0 cycle.
3. **Pointer wrap:** with `ptr`=2 (after a grant to 1), `req`=0011 → grant goes to 0, and `ptr` becomes 1.
4. **Owner drops request:** owner 2 drops `req[2]` with no `release` → `valid`=0 next cycle. A pending `req[3]` is granted one cycle after that.
5. **Timeout:** with `ARB_TIMEOUT_EN` and MAX_HOLD=4, `req`=0110, owner 1 never releases → `valid` is high 4 cycles, then `timeout`=1 and `gnt`=0000 for one cycle, then `gnt`=0100. Without the macro, `gnt`=0010 holds for 20 or more cycles and `timeout` stays 0.
6. **Reset mid-grant:** `rst`=1 while `gnt`=1000 → next edge all outputs at reset values, `timeout`=0. A subsequent `req`=1001 is granted to 0 (`ptr` was reset).
